// File: rtl/tmds_pkg.sv
// Shared TMDS receive definitions: control tokens, symbol width, aligner FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Tokens are written q[9]..q[0]; q[0] is the first bit on the wire.
package tmds_pkg;

  localparam int SYMBOL_BITS = 10;

  // Control-period tokens, indexed by {c1, c0}
  localparam logic [SYMBOL_BITS-1:0] TOK_00 = 10'b1101010100;
  localparam logic [SYMBOL_BITS-1:0] TOK_01 = 10'b0010101011;
  localparam logic [SYMBOL_BITS-1:0] TOK_10 = 10'b0101010100;
  localparam logic [SYMBOL_BITS-1:0] TOK_11 = 10'b1010101011;

  // Symbol aligner states
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Result of decoding one 10-bit symbol
  typedef struct packed {
    logic       is_token;
    logic [1:0] ctl;       // {c1, c0}, meaningful only when is_token=1
    logic [7:0] data;      // meaningful only when is_token=0
  } dec_t;

endpackage

// File: rtl/tmds_decode.sv
// Combinational TMDS 10b symbol decoder: token detect + 8-bit data recovery.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows input every cycle.
//
// Ports:
//   sym  in   10  symbol, q[9]..q[0] with q[0] the oldest bit on the wire
//   dec  out  11  {is_token, ctl[1:0], data[7:0]}
module tmds_decode
  import tmds_pkg::*;
(
  input  logic [SYMBOL_BITS-1:0] sym,
  output dec_t                   dec
);

  logic [7:0] qi;    // data bits after optional inversion
  logic [7:0] dat;

  // q[9] flags an inverted payload; q[8] selects XOR vs XNOR chaining.
  always_comb begin
    qi     = sym[9] ? ~sym[7:0] : sym[7:0];
    dat    = '0;
    dat[0] = qi[0];
    for (int i = 1; i < 8; i++) begin
      dat[i] = sym[8] ? (qi[i] ^ qi[i-1]) : ~(qi[i] ^ qi[i-1]);
    end
  end

  always_comb begin
    dec          = '0;
    dec.data     = dat;
    unique case (sym)
      TOK_00:  begin dec.is_token = 1'b1; dec.ctl = 2'b00; end
      TOK_01:  begin dec.is_token = 1'b1; dec.ctl = 2'b01; end
      TOK_10:  begin dec.is_token = 1'b1; dec.ctl = 2'b10; end
      TOK_11:  begin dec.is_token = 1'b1; dec.ctl = 2'b11; end
      default: begin dec.is_token = 1'b0; dec.ctl = 2'b00; end
    endcase
  end

endmodule

// File: rtl/colorinput.sv
// Serial TMDS channel receiver: bit-level symbol alignment on control tokens, then per-symbol decode.
// Latency: outputs register one cycle after the symbol's last bit is in the window (boundary).
// Backpressure: none; din is consumed every cycle, valid is a one-cycle strobe per symbol.
//
// Ports:
//   clk              in   1  serial bit clock, one TMDS bit per cycle
//   rst              in   1  synchronous active-high reset
//   din              in   1  serial bit, LSB of each symbol first
//   dout             out  8  decoded pixel data (meaningful when blanking=0)
//   blanking         out  1  last decoded symbol was a control token
//   c0, c1           out  1  control bits of the last control token
//   valid            out  1  one-cycle strobe per decoded symbol while locked
//   locked           out  1  symbol alignment established
//   lock_loss_count  out  8  saturating LOCKED->HUNT counter
//
// Build option: define COLORINPUT_LOCKSTAT_EN to include the lock-loss counter;
// otherwise lock_loss_count is tied to 0.
module colorinput #(
  parameter int LOCK_COUNT = 4,
  parameter int MISS_LIMIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic [7:0] dout,
  output logic       blanking,
  output logic       c0,
  output logic       c1,
  output logic       valid,
  output logic       locked,
  output logic [7:0] lock_loss_count
);

  import tmds_pkg::*;

  localparam int TCW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam int MCW = (MISS_LIMIT < 2) ? 1 : $clog2(MISS_LIMIT + 1);
  // With a lock threshold of one, the first token sighting already locks.
  localparam bit FAST_LOCK = (LOCK_COUNT <= 1);

  // ------------------------------------------------------------------
  // Datapath state
  // ------------------------------------------------------------------
  logic [SYMBOL_BITS-1:0] shreg;         // bit 0 = oldest bit
  logic [3:0]             phase;         // 0..9, 9 = symbol boundary
  logic [TCW-1:0]         tok_cnt;       // aligned tokens seen while verifying
  logic [MCW-1:0]         miss_cnt;      // misaligned sightings while locked
  logic                   aligned_seen;  // last boundary carried a token

  state_t state, state_next;
  dec_t   dec;

  tmds_decode u_decode (
    .sym (shreg),
    .dec (dec)
  );

  logic boundary;
  logic miss_hit;
  logic tok_done;
  logic miss_done;

  assign boundary  = (phase == 4'd9);
  // A token in the window at the boundary is aligned by definition, so an
  // aligned and a misaligned sighting can never coincide.
  assign miss_hit  = dec.is_token && !boundary && !aligned_seen;
  assign tok_done  = (tok_cnt >= TCW'(LOCK_COUNT - 1));
  assign miss_done = (miss_cnt >= MCW'(MISS_LIMIT - 1));

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
    end else begin
      state <= state_next;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      HUNT: begin
        if (dec.is_token) begin
          state_next = FAST_LOCK ? LOCKED : VERIFY;
        end
      end
      VERIFY: begin
        if (boundary) begin
          if (!dec.is_token) begin
            state_next = HUNT;
          end else if (tok_done) begin
            state_next = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (miss_hit && miss_done) begin
          state_next = HUNT;
        end
      end
      default: state_next = HUNT;
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: output logic (next values of the registered outputs)
  // ------------------------------------------------------------------
  logic [7:0] dout_n;
  logic       blank_n;
  logic       c0_n;
  logic       c1_n;
  logic       valid_n;

  always_comb begin
    dout_n  = dout;
    blank_n = blanking;
    c0_n    = c0;
    c1_n    = c1;
    valid_n = 1'b0;
    if (state == LOCKED && boundary) begin
      valid_n = 1'b1;
      if (dec.is_token) begin
        blank_n = 1'b1;
        c0_n    = dec.ctl[0];
        c1_n    = dec.ctl[1];
      end else begin
        blank_n = 1'b0;
        dout_n  = dec.data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout     <= 8'd0;
      blanking <= 1'b1;
      c0       <= 1'b0;
      c1       <= 1'b0;
      valid    <= 1'b0;
      locked   <= 1'b0;
    end else begin
      dout     <= dout_n;
      blanking <= blank_n;
      c0       <= c0_n;
      c1       <= c1_n;
      valid    <= valid_n;
      locked   <= (state_next == LOCKED);
    end
  end

  // ------------------------------------------------------------------
  // Shift register, phase and alignment counters
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg        <= '0;
      phase        <= 4'd0;
      tok_cnt      <= '0;
      miss_cnt     <= '0;
      aligned_seen <= 1'b0;
    end else begin
      shreg <= {din, shreg[SYMBOL_BITS-1:1]};
      phase <= boundary ? 4'd0 : phase + 4'd1;

      if (boundary) begin
        aligned_seen <= dec.is_token;
      end

      unique case (state)
        HUNT: begin
          miss_cnt <= '0;
          if (dec.is_token) begin
            // Window just completed a token: the next cycle is phase 0 of
            // the following symbol.
            phase        <= 4'd0;
            tok_cnt      <= TCW'(1);
            aligned_seen <= 1'b1;
          end
        end
        VERIFY: begin
          miss_cnt <= '0;
          if (boundary && dec.is_token && !tok_done) begin
            tok_cnt <= tok_cnt + TCW'(1);
          end
        end
        LOCKED: begin
          if (boundary && dec.is_token) begin
            miss_cnt <= '0;
          end else if (miss_hit) begin
            miss_cnt <= miss_done ? '0 : miss_cnt + MCW'(1);
          end
        end
        default: begin
          miss_cnt <= '0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Optional lock-loss statistics
  // ------------------------------------------------------------------
`ifdef COLORINPUT_LOCKSTAT_EN
  logic [7:0] loss_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      loss_cnt <= 8'd0;
    end else if (state == LOCKED && state_next == HUNT && loss_cnt != 8'hFF) begin
      loss_cnt <= loss_cnt + 8'd1;
    end
  end

  assign lock_loss_count = loss_cnt;
`else
  assign lock_loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_colorinput.sv
// Directed bench for colorinput: lock, decode, misalignment drop/relock, reset, verify abort.
// Latency: checks sample on the falling edge; strobes captured 2 time units after the rising edge.
// Backpressure: n/a (bench drives one bit per cycle).
module tb_colorinput;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] D1  = 10'b0100000001;  // q9=0 q8=1, q'=01       -> XOR chain  -> 8'h03
  localparam logic [9:0] D2  = 10'b1011111110;  // q9=1 q8=0, q'=~FE=01   -> XNOR chain -> 8'hFD
  localparam logic [9:0] D3  = 10'b0111111111;  // q9=0 q8=1, q'=FF       -> XOR chain  -> 8'h01
  localparam logic [9:0] D4  = 10'b1000000000;  // q9=1 q8=0, q'=~00=FF   -> XNOR chain -> 8'hFF

`ifdef COLORINPUT_LOCKSTAT_EN
  localparam logic [7:0] LLC_EXP = 8'd1;
`else
  localparam logic [7:0] LLC_EXP = 8'd0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic [7:0] dout;
  logic       blanking;
  logic       c0;
  logic       c1;
  logic       valid;
  logic       locked;
  logic [7:0] lock_loss_count;

  colorinput #(.LOCK_COUNT(4), .MISS_LIMIT(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .din             (din),
    .dout            (dout),
    .blanking        (blanking),
    .c0              (c0),
    .c1              (c1),
    .valid           (valid),
    .locked          (locked),
    .lock_loss_count (lock_loss_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Strobe monitor: records every valid pulse and what it carried.
  int         cyc       = 0;
  int         vcnt      = 0;
  int         last_vcyc = 0;
  int         prev_vcyc = 0;
  logic [7:0] v_dout    = 8'd0;
  logic       v_blank   = 1'b0;
  logic       v_c0      = 1'b0;
  logic       v_c1      = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    #2;
    if (valid === 1'b1) begin
      prev_vcyc = last_vcyc;
      last_vcyc = cyc;
      vcnt      = vcnt + 1;
      v_dout    = dout;
      v_blank   = blanking;
      v_c0      = c0;
      v_c1      = c1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    din = b;
    @(negedge clk);
  endtask

  task automatic send_range(input logic [9:0] s, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_bit(s[i]);
  endtask

  task automatic send_sym(input logic [9:0] s);
    send_range(s, 0, 9);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_dout",     {24'd0, dout}, 32'h00);
    chk("rst_blanking", {31'd0, blanking}, 32'd1);
    chk("rst_c0",       {31'd0, c0}, 32'd0);
    chk("rst_c1",       {31'd0, c1}, 32'd0);
    chk("rst_valid",    {31'd0, valid}, 32'd0);
    chk("rst_locked",   {31'd0, locked}, 32'd0);
    chk("rst_llc",      {24'd0, lock_loss_count}, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    din = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    pulse_reset();

    // Lock on aligned 00 tokens: stream bits 0..39 are tokens 1..4.
    repeat (4) send_sym(T00);
    chk("lock_not_yet", {31'd0, locked}, 32'd0);
    send_range(T00, 0, 0);                       // bit 40
    chk("lock_after_4", {31'd0, locked}, 32'd1);
    chk("lock_blank",   {31'd0, blanking}, 32'd1);
    chk("lock_c0",      {31'd0, c0}, 32'd0);
    chk("lock_c1",      {31'd0, c1}, 32'd0);
    chk("lock_no_strobe_yet", vcnt, 32'd0);
    send_range(T00, 1, 9);                       // bits 41..49
    send_sym(T00);                               // bits 50..59, token-5 strobe at 50
    chk("tok5_strobe", vcnt, 32'd1);
    chk("tok5_blank",  {31'd0, v_blank}, 32'd1);

    // Data symbols
    send_sym(D1);                                // bits 60..69
    send_range(D2, 0, 0);                        // bit 70: D1 strobe
    chk("d1_strobes",  vcnt, 32'd3);
    chk("d1_dout",     {24'd0, v_dout}, 32'h03);
    chk("d1_blank",    {31'd0, v_blank}, 32'd0);
    chk("d1_c0_hold",  {31'd0, v_c0}, 32'd0);
    chk("d1_interval", last_vcyc - prev_vcyc, 32'd10);
    send_range(D2, 1, 1);
    chk("valid_one_cycle", {31'd0, valid}, 32'd0);
    send_range(D2, 2, 9);
    send_range(D3, 0, 0);
    chk("d2_dout", {24'd0, v_dout}, 32'hFD);
    send_range(D3, 1, 9);
    send_range(D4, 0, 0);
    chk("d3_dout", {24'd0, v_dout}, 32'h01);
    send_range(D4, 1, 9);
    send_range(T00, 0, 0);                       // bit 100
    chk("d4_dout",  {24'd0, v_dout}, 32'hFF);
    chk("d4_blank", {31'd0, v_blank}, 32'd0);
    send_range(T00, 1, 9);                       // bits 101..109

    // Slip by three junk bits, then a continuous 01 token stream.
    repeat (3) send_bit(1'b0);                   // bits 110..112
    chk("pre_slip_token", {31'd0, v_blank}, 32'd1);
    repeat (8) send_sym(T01);                    // bits 113..192, sightings at 122..192
    chk("hold_lock_7_misses", {31'd0, locked}, 32'd1);
    send_range(T01, 0, 0);                       // bit 193
    chk("drop_after_8_misses", {31'd0, locked}, 32'd0);
    chk("llc_after_drop", {24'd0, lock_loss_count}, {24'd0, LLC_EXP});
    chk("strobes_before_drop", vcnt, 32'd15);
    chk("drop_blank_hold", {31'd0, blanking}, 32'd0);
    chk("drop_c0_hold", {31'd0, c0}, 32'd0);
    send_range(T01, 1, 9);                       // bits 194..202
    repeat (3) send_sym(T01);                    // bits 203..232
    chk("relock_not_yet", {31'd0, locked}, 32'd0);
    send_range(T01, 0, 0);                       // bit 233
    chk("relock", {31'd0, locked}, 32'd1);
    chk("no_strobe_unlocked", vcnt, 32'd15);
    send_range(T01, 1, 9);
    send_range(T01, 0, 0);                       // bit 243: first strobe after relock
    chk("relock_strobe", vcnt, 32'd16);
    chk("relock_c0",    {31'd0, v_c0}, 32'd1);
    chk("relock_c1",    {31'd0, v_c1}, 32'd0);
    chk("relock_blank", {31'd0, v_blank}, 32'd1);
    chk("relock_llc",   {24'd0, lock_loss_count}, {24'd0, LLC_EXP});

    // Reset mid-symbol while locked, then four fresh tokens to relock.
    send_range(T01, 1, 4);
    pulse_reset();
    repeat (4) send_sym(T00);
    chk("post_rst_not_locked", {31'd0, locked}, 32'd0);
    send_range(T00, 0, 0);
    chk("post_rst_locked", {31'd0, locked}, 32'd1);
    chk("post_rst_no_strobe", vcnt, 32'd16);
    send_range(T00, 1, 9);

    // Verify aborted by a data symbol after two tokens.
    pulse_reset();
    repeat (2) send_sym(T00);                    // bits 0..19
    send_sym(D1);                                // bits 20..29
    repeat (2) send_sym(T00);                    // bits 30..49
    send_bit(1'b0);                              // bit 50
    chk("abort_not_locked", {31'd0, locked}, 32'd0);
    repeat (9) send_bit(1'b0);
    send_sym(10'd0);
    chk("abort_still_unlocked", {31'd0, locked}, 32'd0);
    chk("abort_no_strobes", vcnt, 32'd16);
    chk("abort_blank_reset", {31'd0, blanking}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
